// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding unit sitting beside the ID stage.
// Tracks in-flight destination registers in a shift-register scoreboard and
// decides issue / load-use stall / branch flush for the ID instruction.
// Optional build macro: HAZ_PERF_CNT_EN adds stall_cycles / flush_cycles.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned BR_BUBBLES = 2,
  localparam int unsigned FW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              issue,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  localparam int unsigned CW = $clog2(BR_BUBBLES) + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            flush;

  logic [DEPTH-1:0]  sb_valid;
  logic [DEPTH-1:0]  sb_wr;
  logic [DEPTH-1:0]  sb_load;
  logic [REG_AW-1:0] sb_rd [DEPTH];

  logic            haz_a, haz_b;
  logic [FW-1:0]   sel_a, sel_b;

  // Youngest matching producer wins; returns {load_use_hazard, select}.
  function automatic logic [FW:0] search(input logic [REG_AW-1:0] r,
                                         input logic used);
    logic          hit;
    logic          haz;
    logic [FW-1:0] sel;
    hit = 1'b0;
    haz = 1'b0;
    sel = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!hit && used && (r != '0) && sb_valid[k] && sb_wr[k] &&
          (sb_rd[k] == r)) begin
        hit = 1'b1;
        if (k + 1 < DEPTH) begin
          if (sb_load[k] && (k < LOAD_LAT)) haz = 1'b1;
          else                              sel = FW'(k + 1);
        end
      end
    end
    return {haz, sel};
  endfunction

  // Hazard search for both source operands.
  always_comb begin
    {haz_a, sel_a} = search(id_rs, id_uses_rs);
    {haz_b, sel_b} = search(id_rt, id_uses_rt);
  end

  // Flush FSM next-state and flush output; reset suppresses all flushing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    flush    = 1'b0;
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          flush = 1'b1;
          if (BR_BUBBLES > 1) begin
            cnt_nx   = CW'(BR_BUBBLES - 1);
            state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (ex_branch_taken) begin
          cnt_nx = CW'(BR_BUBBLES - 1);
        end else if (cnt == CW'(1)) begin
          cnt_nx   = '0;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
    if (rst) flush = 1'b0;
  end

  // Issue decision: flush outranks stall, reset outranks both.
  always_comb begin
    flush_ifid = flush;
    flush_idex = flush;
    stall      = !rst && id_valid && (haz_a || haz_b) && !flush;
    issue      = !rst && id_valid && !stall && !flush;
  end

  // Flush FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Scoreboard shift: issued instruction enters position 0, else a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
    end else begin
      sb_valid <= {sb_valid[DEPTH-2:0], issue};
    end
    sb_wr   <= {sb_wr[DEPTH-2:0], id_reg_wr};
    sb_load <= {sb_load[DEPTH-2:0], id_is_load};
    sb_rd[0] <= id_rd;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      sb_rd[k] <= sb_rd[k-1];
    end
  end

  // Forwarding selects registered into the instruction's EX cycle.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else begin
      fwd_a <= sel_a;
      fwd_b <= sel_b;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Free-running stall / flush cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall)      stall_cycles <= stall_cycles + 32'd1;
      if (flush_idex) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with a queue scoreboard.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_reg_wr, id_is_load;
  logic       ex_branch_taken;
  logic       stall, flush_ifid, flush_idex, issue;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [7:0] exp;
  } rec_t;
  rec_t q[$];

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .BR_BUBBLES(2)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .issue(issue), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
  );

  // Monitor: every cycle with a pending expectation, compare all outputs.
  initial begin
    rec_t r;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r   = q.pop_front();
        act = {stall, flush_ifid, flush_idex, issue, fwd_a, fwd_b};
        checks++;
        if (act !== r.exp) begin
          errors++;
          $display("FAIL %s got {stall,fl_ifid,fl_idex,issue,fa,fb}=%b expected %b",
                   r.nm, act, r.exp);
        end
      end
    end
  end

  // One cycle of stimulus; expected fwd values are those of the instruction now in EX.
  task automatic cyc(input string nm, input logic r, v, br,
                     input logic [4:0] rs, rt, rd,
                     input logic urs, urt, wr, ld,
                     input logic st, fl, is, input logic [1:0] fa, fb);
    rec_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; ex_branch_taken = br;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_reg_wr = wr; id_is_load = ld;
    e.nm  = nm;
    e.exp = {st, fl, fl, is, fa, fb};
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [1:0] fa, fb);
    cyc(nm, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0, fa,fb);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; ex_branch_taken = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_reg_wr = 0; id_is_load = 0;
    repeat (2) @(posedge clk);

    //          r v b  rs rt rd  urs urt wr ld  st fl is  fa fb
    cyc("rst",       1,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0);
    // 1: back-to-back dependency -> EX/MEM forward
    cyc("s1_add3",   0,1,0, 1,2,3, 1,1,1,0, 0,0,1, 0,0);
    cyc("s1_use3",   0,1,0, 3,4,6, 1,1,1,0, 0,0,1, 0,0);
    idle("s1_ex", 1, 0);
    // 2: one gap -> MEM/WB forward; two gaps -> register file
    cyc("s2_add7",   0,1,0, 1,2,7, 1,1,1,0, 0,0,1, 0,0);
    idle("s2_nop", 0, 0);
    cyc("s2_use7",   0,1,0, 7,0,0, 1,1,0,0, 0,0,1, 0,0);
    cyc("s2_use7_l", 0,1,0, 7,0,0, 1,1,0,0, 0,0,1, 2,0);
    idle("s2_ex_l", 0, 0);
    // 3: load-use stall of one cycle, then forward from MEM/WB
    cyc("s3_lw5",    0,1,0, 1,0,5, 1,0,1,1, 0,0,1, 0,0);
    cyc("s3_stall",  0,1,0, 1,5,8, 1,1,1,0, 1,0,0, 0,0);
    cyc("s3_issue",  0,1,0, 1,5,8, 1,1,1,0, 0,0,1, 0,0);
    idle("s3_ex", 0, 2);
    // 4: register 0 never matches; youngest producer wins
    cyc("s4_lw0",    0,1,0, 0,0,0, 0,0,1,1, 0,0,1, 0,0);
    cyc("s4_use0",   0,1,0, 0,0,0, 1,1,0,0, 0,0,1, 0,0);
    idle("s4_ex0", 0, 0);
    cyc("s4_w3a",    0,1,0, 0,0,3, 0,0,1,0, 0,0,1, 0,0);
    cyc("s4_w3b",    0,1,0, 0,0,3, 0,0,1,0, 0,0,1, 0,0);
    cyc("s4_young",  0,1,0, 3,3,0, 1,1,0,0, 0,0,1, 0,0);
    idle("s4_ex_y", 1, 1);
    // 5: taken branch flushes two cycles; flushed rd 9 never recorded
    cyc("s5_br",     0,1,1, 0,0,9, 0,0,1,0, 0,1,0, 0,0);
    cyc("s5_fl2",    0,1,0, 0,0,9, 0,0,1,0, 0,1,0, 0,0);
    cyc("s5_after",  0,1,0, 9,0,0, 1,0,0,0, 0,0,1, 0,0);
    idle("s5_ex", 0, 0);
    cyc("s5_lw5",    0,1,0, 0,0,5, 0,0,1,1, 0,0,1, 0,0);
    cyc("s5_br_stl", 0,1,1, 0,5,0, 0,1,0,0, 0,1,0, 0,0);
    cyc("s5_fl_b",   0,1,0, 0,5,0, 0,1,0,0, 0,1,0, 0,0);
    cyc("s5_resume", 0,1,0, 0,5,0, 0,1,0,0, 0,0,1, 0,0);
    idle("s5_ex_r", 0, 0);
    // 6: reset mid-stall clears scoreboard; reset mid-flush returns to RUN
    cyc("s6_lw5",    0,1,0, 0,0,5, 0,0,1,1, 0,0,1, 0,0);
    cyc("s6_rst_st", 1,1,0, 0,5,0, 0,1,0,0, 0,0,0, 0,0);
    cyc("s6_post",   0,1,0, 0,5,0, 0,1,0,0, 0,0,1, 0,0);
    idle("s6_ex", 0, 0);
    cyc("s6_br",     0,0,1, 0,0,0, 0,0,0,0, 0,1,0, 0,0);
    cyc("s6_rst_fl", 1,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0);
    cyc("s6_run",    0,1,0, 0,0,1, 0,0,1,0, 0,0,1, 0,0);
    cyc("s6_lw5b",   0,1,0, 0,0,5, 0,0,1,1, 0,0,1, 0,0);
    cyc("s6_stl_b",  0,1,0, 1,5,8, 1,1,1,0, 1,0,0, 0,0);
    cyc("s6_iss_b",  0,1,0, 1,5,8, 1,1,1,0, 0,0,1, 0,0);
    idle("s6_ex_b", 0, 2);

    @(negedge clk);
    #1;
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected 1", stall_cycles);
    end
    checks++;
    if (flush_cycles !== 32'd0) begin
      errors++;
      $display("FAIL flush_cycles got %0d expected 0", flush_cycles);
    end
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard detection and forwarding unit for the pipelined CPU. It sits beside the ID stage and replaces the empty hazard stub.
- Keeps a shift-register scoreboard of in-flight destination registers and decides, per ID instruction, one of three outcomes: issue, stall (load-use), or flush (taken branch).
- Produces registered forwarding selects for both ALU operands, aligned with the EX stage.

Parameters:
- REG_AW, 5: register address width.
- DEPTH, 3: tracked stages after ID (position 0 = EX, 1 = MEM, 2 = WB, ...); minimum 2.
- LOAD_LAT, 1: position at which load data leaves the pipeline stage; a load's value is forwardable only from a latch feeding position > LOAD_LAT.
- BR_BUBBLES, 2: cycles of IF/ID and ID/EX flush after a taken branch; minimum 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source A register.
- id_rt  in  REG_AW  source B register.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_rd  in  REG_AW  destination register, already muxed by RegDst.
- id_reg_wr  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is lw.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- issue  out  1  ID instruction advances into EX this cycle.
- fwd_a  out  FW  EX operand A select, FW = clog2(DEPTH).
- fwd_b  out  FW  EX operand B select, same encoding as fwd_a.

Behaviour:
Scoreboard
- Entry s[k] holds {valid, rd, reg_wr, is_load} for the instruction now at position k.
- Every cycle: s[k+1] <= s[k]. s[0] <= ID fields when issue, otherwise a bubble (valid = 0).
- The entry at s[DEPTH-1] retires.

Hazard search (combinational)
- Performed per used source register r with r != 0.
- Find the smallest k with s[k].valid & s[k].reg_wr & s[k].rd == r. The youngest producer wins.
- No match, or k+1 >= DEPTH: select 0 (register file).
- Match with s[k].is_load & k < LOAD_LAT: load-use hazard.
- Otherwise: select k+1.
  - 1 = EX/MEM latch.
  - 2 = MEM/WB latch.
  - Higher codes = later latches.
- Register 0 never matches, never stalls, and always selects 0.

Outputs
- stall = id_valid & (hazard on rs | hazard on rt) & !flush_idex.
- issue = id_valid & !stall & !flush_idex.
- fwd_a and fwd_b are registered.
  - On issue: load the computed selects.
  - Otherwise: load 0.
  - Latency is 1 cycle, aligned with the instruction's EX cycle.
- A load at k = 0 with LOAD_LAT = 1 stalls exactly 1 cycle, then issues with select 2. Larger LOAD_LAT gives LOAD_LAT - k stall cycles.

Flush FSM (states RUN, FLUSH; counter cnt of width clog2(BR_BUBBLES)+1)
- RUN:
  - ex_branch_taken asserts flush_ifid = flush_idex = 1 combinationally in the same cycle.
  - If BR_BUBBLES > 1: cnt <= BR_BUBBLES-1 and go to FLUSH.
- FLUSH:
  - Flush outputs are 1; cnt decrements.
  - Return to RUN when cnt reaches 1.
  - A new ex_branch_taken reloads cnt to BR_BUBBLES-1.
- Flush has priority over stall. A flushed ID instruction never enters the scoreboard.

Reset
- rst outranks all other inputs, including mid-stall and mid-flush.
- All scoreboard valid bits = 0; fwd_a = fwd_b = 0; FSM = RUN; cnt = 0.
- In the reset cycle: stall = 0, flush_ifid = flush_idex = 0, issue = 0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles [31:0] and flush_cycles [31:0], both free-running.
  - stall_cycles increments every cycle stall = 1; flush_cycles increments every cycle flush_idex = 1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
1. Defaults; issue add $3 (rd 3); next cycle issue add using rs = 3 -> stall = 0, fwd_a = 1 in its EX cycle.
2. add $3, nop, then a consumer of rs = 3 -> fwd_a = 2. A consumer three cycles later gets fwd_a = 0.
3. lw $5, then immediately a consumer of rt = 5 -> stall = 1 for exactly 1 cycle, issue = 0 that cycle, then issue with fwd_b = 2.
4. lw $0, then a consumer of rs = 0 -> no stall, fwd_a = 0. Also: writers of $3 at k = 0 and k = 1 -> fwd_a = 1 (youngest wins).
5. ex_branch_taken pulsed 1 cycle, BR_BUBBLES = 2 -> flush_ifid/flush_idex high 2 cycles, both flushed instructions absent from the scoreboard. A branch arriving while stall = 1 -> flush wins, stall = 0.
6. rst asserted mid-stall and mid-flush -> next cycle all outputs 0, FSM in RUN. With HAZ_PERF_CNT_EN defined and scenario 3 run after reset -> stall_cycles = 1.
